// File: rtl/r4k_pkg.sv
// Shared types and helpers for the r4k HI/LO multiply/divide unit.
package r4k_pkg;

  // Widest XLEN the sign-extension helper can serve; callers cast down to their own width.
  localparam int MAX_XLEN = 128;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_e;

  function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(MAX_XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/r4k_div_iter.sv
// Restoring unsigned divider datapath: one quotient bit per step, XLEN steps per divide.
module r4k_div_iter
  import r4k_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] dvsr;
  logic [CW-1:0]   left;
  logic [XLEN:0]   trial;

  // Subtract the divisor from the partial remainder with the next dividend bit shifted in; top bit is the borrow.
  always_comb begin
    trial = {remainder, quotient[XLEN-1]} - {1'b0, dvsr};
  end

  assign busy = (left != '0);

  // Load operands on start, then retire one quotient bit per step, restoring the remainder on borrow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dvsr      <= '0;
      left      <= '0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dvsr      <= divisor;
      left      <= CW'(XLEN);
    end else if (step && busy) begin
      if (!trial[XLEN]) begin
        remainder <= trial[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], 1'b1};
      end else begin
        remainder <= {remainder[XLEN-2:0], quotient[XLEN-1]};
        quotient  <= {quotient[XLEN-2:0], 1'b0};
      end
      left <= left - CW'(1);
    end
  end

endmodule

// File: rtl/r4k_muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: shift-add multiplier, restoring divider, sign fix-up, kill abort.
module r4k_muldiv_unit
  import r4k_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              MUL_BITS = 4,
  parameter logic [XLEN-1:0] START_HI = '0,
  parameter logic [XLEN-1:0] START_LO = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      op,
  input  logic            op_word,
  input  logic            kill,
  input  logic [XLEN-1:0] rs_value,
  input  logic [XLEN-1:0] rt_value,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(XLEN) + 1;

  muldiv_state_e state, state_next;

  logic [CW-1:0]          cnt;
  logic [XLEN-1:0]        opa;
  logic [2*XLEN-1:0]      acc;
  logic                   sa, sb, word_r, div_r, bzero_r, mt_done;

  logic                   accept, is_signed, is_mul_op, is_div_op, is_mt_op;
  logic [XLEN-1:0]        a_ext, b_ext, a_abs, b_abs;
  logic                   a_neg, b_neg;

  logic [XLEN+MUL_BITS-1:0] partial, upper;
  logic [2*XLEN-1:0]      mul_next, prod;

  logic [XLEN-1:0]        div_quo, div_rem, quo_s, rem_s, a_val;
  logic                   div_busy, div_step;
  logic [XLEN-1:0]        fix_hi, fix_lo;

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'(sext32(v));
  endfunction

  function automatic logic [XLEN-1:0] zx(input logic [31:0] v);
    return XLEN'(v);
  endfunction

  // Decode the request and prepare operand magnitudes plus sign flags for the signed ops.
  always_comb begin
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    is_mt_op  = (op == OP_MTHI) || (op == OP_MTLO);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    accept    = start_valid && start_ready && !kill && (op <= 3'd5);
    a_ext     = rs_value;
    b_ext     = rt_value;
    if (op_word) begin
      a_ext = is_signed ? sx(rs_value[31:0]) : zx(rs_value[31:0]);
      b_ext = is_signed ? sx(rt_value[31:0]) : zx(rt_value[31:0]);
    end
    a_neg = is_signed && a_ext[XLEN-1];
    b_neg = is_signed && b_ext[XLEN-1];
    a_abs = a_neg ? -a_ext : a_ext;
    b_abs = b_neg ? -b_ext : b_ext;
  end

  // One multiplier step: add MUL_BITS shifted copies of the multiplicand into the upper half, then shift right.
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (acc[i]) begin
        partial = partial + ({{MUL_BITS{1'b0}}, opa} << i);
      end
    end
    upper    = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]} + partial;
    mul_next = {upper, acc[XLEN-1:MUL_BITS]};
  end

  assign div_step = (state == DIV) && !kill && !bzero_r && div_busy;

  r4k_div_iter #(
    .XLEN (XLEN)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_div_op),
    .step      (div_step),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (div_quo),
    .remainder (div_rem),
    .busy      (div_busy)
  );

  // Apply result signs and map product/quotient/remainder onto HI/LO for the current width mode.
  always_comb begin
    prod  = (sa ^ sb) ? -acc : acc;
    quo_s = (sa ^ sb) ? -div_quo : div_quo;
    rem_s = sa ? -div_rem : div_rem;
    a_val = sa ? -opa : opa;
    if (!div_r) begin
      fix_hi = word_r ? sx(prod[63:32]) : prod[2*XLEN-1:XLEN];
      fix_lo = word_r ? sx(prod[31:0])  : prod[XLEN-1:0];
    end else if (bzero_r) begin
      fix_hi = word_r ? sx(a_val[31:0]) : a_val;
      fix_lo = '1;
    end else begin
      fix_hi = word_r ? sx(rem_s[31:0]) : rem_s;
      fix_lo = word_r ? sx(quo_s[31:0]) : quo_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs; kill drops any in-flight op and suppresses its done.
  always_comb begin
    state_next  = state;
    start_ready = (state == IDLE);
    busy        = (state != IDLE);
    done        = mt_done || ((state == FIX) && !kill);
    case (state)
      IDLE: begin
        if (accept && is_mul_op) begin
          state_next = MUL;
        end else if (accept && is_div_op) begin
          state_next = DIV;
        end
      end
      MUL: begin
        if (kill) begin
          state_next = IDLE;
        end else if (cnt == CW'(1)) begin
          state_next = FIX;
        end
      end
      DIV: begin
        if (kill) begin
          state_next = IDLE;
        end else if (bzero_r || (cnt == CW'(1))) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand latching, multiplier accumulation, iteration count and architectural HI/LO updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_out  <= START_HI;
      lo_out  <= START_LO;
      mt_done <= 1'b0;
      cnt     <= '0;
      opa     <= '0;
      acc     <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      word_r  <= 1'b0;
      div_r   <= 1'b0;
      bzero_r <= 1'b0;
    end else begin
      mt_done <= accept && is_mt_op;
      if (accept) begin
        if (op == OP_MTHI) begin
          hi_out <= rs_value;
        end
        if (op == OP_MTLO) begin
          lo_out <= rs_value;
        end
        sa      <= a_neg;
        sb      <= b_neg;
        word_r  <= op_word;
        div_r   <= is_div_op;
        bzero_r <= (b_abs == '0);
        opa     <= a_abs;
        acc     <= {{XLEN{1'b0}}, b_abs};
        cnt     <= is_div_op ? CW'(XLEN) : CW'(XLEN / MUL_BITS);
      end
      if ((state == MUL) && !kill) begin
        acc <= mul_next;
        cnt <= cnt - CW'(1);
      end
      if ((state == DIV) && !kill) begin
        cnt <= cnt - CW'(1);
      end
      if ((state == FIX) && !kill) begin
        hi_out <= fix_hi;
        lo_out <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_r4k_muldiv_unit.sv
// Directed self-checking bench for r4k_muldiv_unit (XLEN=64, MUL_BITS=4).
module tb_r4k_muldiv_unit;

  localparam logic [2:0] T_MULT  = 3'd0;
  localparam logic [2:0] T_MULTU = 3'd1;
  localparam logic [2:0] T_DIV   = 3'd2;
  localparam logic [2:0] T_DIVU  = 3'd3;
  localparam logic [2:0] T_MTHI  = 3'd4;
  localparam logic [2:0] T_MTLO  = 3'd5;

  logic        clk;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [2:0]  op;
  logic        op_word;
  logic        kill;
  logic [63:0] rs_value;
  logic [63:0] rt_value;
  logic [63:0] hi_out;
  logic [63:0] lo_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  r4k_muldiv_unit #(
    .XLEN     (64),
    .MUL_BITS (4),
    .START_HI (64'h0),
    .START_LO (64'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .op_word     (op_word),
    .kill        (kill),
    .rs_value    (rs_value),
    .rt_value    (rt_value),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for a single accept edge, then drop start_valid.
  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    op = o; op_word = w; rs_value = a; rt_value = b; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Count cycles after the accept edge until done is seen; gives up at 200.
  task automatic wait_done(input int already, output int lat);
    lat = already;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 200);
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b0; kill = 1'b0; op = 3'd0; op_word = 1'b0;
    rs_value = '0; rt_value = '0;
    repeat (2) @(negedge clk);
    checks++; if (hi_out !== 64'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected %h", hi_out, 64'h0); end
    checks++; if (lo_out !== 64'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected %h", lo_out, 64'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", start_ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (start_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 1", start_ready); end
  endtask

  task automatic test_mt_back_to_back();
    @(negedge clk);
    op = T_MTHI; op_word = 1'b0; rs_value = 64'h1234; start_valid = 1'b1;
    @(posedge clk);
    #1;
    op = T_MTLO; rs_value = 64'h55;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL mthi_done: got %b expected 1", done); end
    checks++; if (hi_out !== 64'h1234) begin errors++; $display("[TB] FAIL mthi_hi: got %h expected %h", hi_out, 64'h1234); end
    checks++; if (lo_out !== 64'h0) begin errors++; $display("[TB] FAIL mthi_lo_kept: got %h expected %h", lo_out, 64'h0); end
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL mtlo_done: got %b expected 1", done); end
    checks++; if (lo_out !== 64'h55) begin errors++; $display("[TB] FAIL mtlo_lo: got %h expected %h", lo_out, 64'h55); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mt_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mt_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_mult_signed();
    int lat;
    issue(T_MULT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mult_busy: got %b expected 1", busy); end
    checks++; if (hi_out !== 64'h1234) begin errors++; $display("[TB] FAIL mult_hi_while_busy: got %h expected %h", hi_out, 64'h1234); end
    wait_done(1, lat);
    checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected 17", lat); end
    @(negedge clk);
    checks++; if (hi_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected %h", hi_out, 64'hFFFF_FFFF_FFFF_FFFF); end
    checks++; if (lo_out !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("[TB] FAIL mult_lo: got %h expected %h", lo_out, 64'hFFFF_FFFF_FFFF_FFEB); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_multu_word();
    int lat;
    issue(T_MULTU, 1'b1, 64'hAAAA_AAAA_FFFF_FFFF, 64'h5555_5555_0000_0002);
    wait_done(0, lat);
    checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL multu_w_latency: got %0d expected 17", lat); end
    @(negedge clk);
    checks++; if (lo_out !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("[TB] FAIL multu_w_lo: got %h expected %h", lo_out, 64'hFFFF_FFFF_FFFF_FFFE); end
    checks++; if (hi_out !== 64'h1) begin errors++; $display("[TB] FAIL multu_w_hi: got %h expected %h", hi_out, 64'h1); end
  endtask

  task automatic test_kill();
    int ndone;
    issue(T_MULT, 1'b0, 64'd3, 64'd5);
    repeat (5) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    checks++; if (start_ready !== 1'b1) begin errors++; $display("[TB] FAIL kill_idle: got %b expected 1", start_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy: got %b expected 0", busy); end
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("[TB] FAIL kill_no_done: got %0d expected 0", ndone); end
    checks++; if (hi_out !== 64'h1) begin errors++; $display("[TB] FAIL kill_hi: got %h expected %h", hi_out, 64'h1); end
    checks++; if (lo_out !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("[TB] FAIL kill_lo: got %h expected %h", lo_out, 64'hFFFF_FFFF_FFFF_FFFE); end
    @(negedge clk);
    op = T_MTHI; op_word = 1'b0; rs_value = 64'hBAD; start_valid = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL kill_start_done: got %b expected 0", done); end
    checks++; if (hi_out !== 64'h1) begin errors++; $display("[TB] FAIL kill_start_hi: got %h expected %h", hi_out, 64'h1); end
  endtask

  task automatic test_divu_word();
    int lat;
    issue(T_DIVU, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007);
    wait_done(0, lat);
    checks++; if (lat !== 65) begin errors++; $display("[TB] FAIL divu_w_latency: got %0d expected 65", lat); end
    @(negedge clk);
    checks++; if (lo_out !== 64'd14) begin errors++; $display("[TB] FAIL divu_w_lo: got %h expected %h", lo_out, 64'd14); end
    checks++; if (hi_out !== 64'd2) begin errors++; $display("[TB] FAIL divu_w_hi: got %h expected %h", hi_out, 64'd2); end
  endtask

  task automatic test_div_signed();
    int lat;
    issue(T_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_done(0, lat);
    checks++; if (lat !== 65) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 65", lat); end
    @(negedge clk);
    checks++; if (lo_out !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected %h", lo_out, 64'hFFFF_FFFF_FFFF_FFFD); end
    checks++; if (hi_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected %h", hi_out, 64'hFFFF_FFFF_FFFF_FFFF); end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(T_DIV, 1'b0, 64'd5, 64'd0);
    wait_done(0, lat);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL divz_latency: got %0d expected 2", lat); end
    @(negedge clk);
    checks++; if (lo_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL divz_lo: got %h expected %h", lo_out, 64'hFFFF_FFFF_FFFF_FFFF); end
    checks++; if (hi_out !== 64'd5) begin errors++; $display("[TB] FAIL divz_hi: got %h expected %h", hi_out, 64'd5); end
  endtask

  task automatic test_div_overflow();
    int lat;
    issue(T_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(0, lat);
    checks++; if (lat !== 65) begin errors++; $display("[TB] FAIL divov_latency: got %0d expected 65", lat); end
    @(negedge clk);
    checks++; if (lo_out !== 64'h8000_0000_0000_0000) begin errors++; $display("[TB] FAIL divov_lo: got %h expected %h", lo_out, 64'h8000_0000_0000_0000); end
    checks++; if (hi_out !== 64'h0) begin errors++; $display("[TB] FAIL divov_hi: got %h expected %h", hi_out, 64'h0); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    @(negedge clk);
    op = T_MULTU; op_word = 1'b0; rs_value = 64'd3; rt_value = 64'd4; start_valid = 1'b1;
    @(posedge clk);
    #1;
    rs_value = 64'd9; rt_value = 64'd9;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        start_valid = 1'b0;
      end
    end
    start_valid = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("[TB] FAIL hold_done_count: got %0d expected 1", ndone); end
    checks++; if (lo_out !== 64'd12) begin errors++; $display("[TB] FAIL hold_lo: got %h expected %h", lo_out, 64'd12); end
    checks++; if (hi_out !== 64'd0) begin errors++; $display("[TB] FAIL hold_hi: got %h expected %h", hi_out, 64'd0); end
  endtask

  task automatic test_reset_mid_div();
    int ndone;
    issue(T_MTHI, 1'b0, 64'hAA, 64'd0);
    issue(T_MTLO, 1'b0, 64'hBB, 64'd0);
    issue(T_DIVU, 1'b0, 64'd1000, 64'd3);
    repeat (20) @(negedge clk);
    checks++; if (hi_out !== 64'hAA) begin errors++; $display("[TB] FAIL rdiv_hi_before: got %h expected %h", hi_out, 64'hAA); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("[TB] FAIL rdiv_ready: got %b expected 1", start_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rdiv_busy: got %b expected 0", busy); end
    checks++; if (hi_out !== 64'h0) begin errors++; $display("[TB] FAIL rdiv_hi: got %h expected %h", hi_out, 64'h0); end
    checks++; if (lo_out !== 64'h0) begin errors++; $display("[TB] FAIL rdiv_lo: got %h expected %h", lo_out, 64'h0); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rdiv_done: got %b expected 0", done); end
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("[TB] FAIL rdiv_no_done: got %0d expected 0", ndone); end
    checks++; if (lo_out !== 64'h0) begin errors++; $display("[TB] FAIL rdiv_lo_after: got %h expected %h", lo_out, 64'h0); end
  endtask

  initial begin
    $display("[TB] starting r4k_muldiv_unit bench");
    test_reset();
    test_mt_back_to_back();
    test_mult_signed();
    test_multu_word();
    test_kill();
    test_divu_word();
    test_div_signed();
    test_div_zero();
    test_div_overflow();
    test_back_to_back();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
